// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// Pure declarations; no logic, no latency.
package bcd_pkg;

    localparam int BIN_W_DEF  = 27;
    localparam int DIGITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Largest value the 8-digit display can show; anything above saturates.
    localparam longint unsigned SAT_VALUE = 64'd99_999_999;

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle between the count latch and the display path.
// start/bin_in flow in, busy/done and the eight BCD digits plus ovf flow out.
interface bcd_seq_converter_if
    import bcd_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
);

    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       one;
    logic [3:0]       ten;
    logic [3:0]       hundred;
    logic [3:0]       thousands;
    logic [3:0]       ten_thousands;
    logic [3:0]       hundred_thousands;
    logic [3:0]       millions;
    logic [3:0]       ten_millions;

    modport master (
        output start, bin_in,
        input  busy, done, ovf,
        input  one, ten, hundred, thousands,
        input  ten_thousands, hundred_thousands, millions, ten_millions
    );

    modport slave (
        input  start, bin_in,
        output busy, done, ovf,
        output one, ten, hundred, thousands,
        output ten_thousands, hundred_thousands, millions, ten_millions
    );

endinterface

// File: rtl/bcd_seq_converter_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
// Combinational, zero latency; 4-bit result never carries since 9+3 = 12.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, saturating at 99,999,999.
// Start accepted in IDLE only; done pulses BIN_W+1 cycles later; start while busy is dropped.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF,
    parameter int CNT_W  = 5
)(
    input  logic                 clk,
    input  logic                 reset,
    bcd_seq_converter_if.slave   bus
);

    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int RES_W = 4 * DIGITS;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_nxt;
    logic [BIN_W-1:0]   shreg;
    logic [BIN_W-1:0]   shreg_nxt;
    logic [SCR_W-1:0]   corr;
    logic [SCR_W+BIN_W-1:0] shifted;
    logic [RES_W-1:0]   result;
    logic [RES_W-1:0]   result_nxt;
    logic               ovf_q;
    logic               ovf_nxt;
    logic               load_out;

    // Every scratch digit is corrected in parallel on the pre-shift value.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (corr[4*g +: 4])
        );
    end

    assign shifted = {corr, shreg} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            scratch <= '0;
            shreg   <= '0;
            result  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            scratch <= scratch_nxt;
            shreg   <= shreg_nxt;
            if (load_out) begin
                result <= result_nxt;
                ovf_q  <= ovf_nxt;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        scratch_nxt = scratch;
        shreg_nxt   = shreg;
        load_out    = 1'b0;
        ovf_nxt     = 1'b0;
        result_nxt  = shifted[BIN_W +: RES_W];

        // The top digit of the final scratch is only non-zero above 99,999,999.
        if (shifted[BIN_W + RES_W +: 4] != 4'd0) begin
            ovf_nxt    = 1'b1;
            result_nxt = {DIGITS{BCD_MAX_DIGIT}};
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_nxt   = bus.bin_in;
                    scratch_nxt = '0;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_nxt = shifted[BIN_W +: SCR_W];
                shreg_nxt   = shifted[BIN_W-1:0];
                cnt_nxt     = cnt + 1'b1;
                // Outputs load on the last shift so they are valid alongside done in FINISH.
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_nxt = FINISH;
                    load_out  = 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy              = (state == SHIFT);
    assign bus.done              = (state == FINISH);
    assign bus.ovf               = ovf_q;
    assign bus.one               = result[3:0];
    assign bus.ten               = result[7:4];
    assign bus.hundred           = result[11:8];
    assign bus.thousands         = result[15:12];
    assign bus.ten_thousands     = result[19:16];
    assign bus.hundred_thousands = result[23:20];
    assign bus.millions          = result[27:24];
    assign bus.ten_millions      = result[31:28];

endmodule
